// File: rtl/plateau_detect_ctrl.sv
// Plateau detection controller: flushes/warms the running-sum windows, then searches for a
// sustained correlation plateau. Optional det_count statistics under PLATEAU_DETECT_CTRL_STATS_EN.
module plateau_detect_ctrl #(
    parameter int SUM_WIDTH   = 22,
    parameter int WARMUP_LEN  = 64,
    parameter int MIN_HITS    = 48,
    parameter int HOLDOFF_LEN = 160
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 restart,
    input  logic                 src_valid,
    output logic                 sum_in_valid,
    output logic                 win_rstn,
    input  logic [SUM_WIDTH-1:0] sum_corr,
    input  logic [SUM_WIDTH-1:0] sum_pwr,
    input  logic                 sum_valid,
    input  logic [2:0]           thresh_num,
    output logic                 detected,
    output logic [2:0]           state
`ifdef PLATEAU_DETECT_CTRL_STATS_EN
    ,
    output logic [15:0]          det_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        WARMUP = 3'd2,
        SEARCH = 3'd3,
        DETECT = 3'd4,
        HOLD   = 3'd5
    } state_t;

    localparam int FLUSH_LEN = 2;
    localparam int FW = $clog2(FLUSH_LEN) + 1;
    localparam int WW = $clog2(WARMUP_LEN) + 1;
    localparam int HW = $clog2(MIN_HITS) + 1;
    localparam int OW = $clog2(HOLDOFF_LEN) + 1;
    localparam int PW = SUM_WIDTH + 3;

    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
    localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP_LEN - 1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(MIN_HITS - 1);
    localparam logic [OW-1:0] HOLD_LAST  = OW'(HOLDOFF_LEN - 1);

    state_t        state_q, state_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [WW-1:0] warm_q, warm_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [OW-1:0] hold_q, hold_d;
    logic          win_rstn_q, win_rstn_d;
    logic          detected_q, detected_d;

    logic [PW-1:0] corr_ext;
    logic [PW-1:0] pwr_scaled;
    logic          hit;

    // sum_pwr < 2^W and thresh_num < 8, so the product always fits in W+3 bits
    assign corr_ext   = {sum_corr, 3'b000};
    assign pwr_scaled = PW'(sum_pwr) * PW'(thresh_num);
    assign hit        = (corr_ext > pwr_scaled) && (sum_pwr != '0);

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        warm_d     = warm_q;
        hit_d      = hit_q;
        hold_d     = hold_q;
        win_rstn_d = win_rstn_q;
        detected_d = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            flush_d    = '0;
            warm_d     = '0;
            hit_d      = '0;
            hold_d     = '0;
            win_rstn_d = 1'b0;
        end else if (restart && state_q != IDLE) begin
            state_d    = FLUSH;
            flush_d    = '0;
            warm_d     = '0;
            hit_d      = '0;
            hold_d     = '0;
            win_rstn_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = FLUSH;
                    flush_d    = '0;
                    warm_d     = '0;
                    hit_d      = '0;
                    hold_d     = '0;
                    win_rstn_d = 1'b0;
                end
                FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        state_d    = WARMUP;
                        flush_d    = '0;
                        win_rstn_d = 1'b1;
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end
                WARMUP: begin
                    if (sum_valid) begin
                        if (warm_q == WARM_LAST) begin
                            state_d = SEARCH;
                            warm_d  = '0;
                            hit_d   = '0;
                        end else begin
                            warm_d = warm_q + 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (sum_valid) begin
                        if (!hit) begin
                            hit_d = '0;
                        end else if (hit_q == HIT_LAST) begin
                            state_d    = DETECT;
                            hit_d      = hit_q + 1'b1;
                            detected_d = 1'b1;
                        end else begin
                            hit_d = hit_q + 1'b1;
                        end
                    end
                end
                DETECT: begin
                    state_d = HOLD;
                    hit_d   = '0;
                    hold_d  = '0;
                end
                HOLD: begin
                    if (sum_valid) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = SEARCH;
                            hold_d  = '0;
                            hit_d   = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    win_rstn_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            flush_q    <= '0;
            warm_q     <= '0;
            hit_q      <= '0;
            hold_q     <= '0;
            win_rstn_q <= 1'b0;
            detected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            warm_q     <= warm_d;
            hit_q      <= hit_d;
            hold_q     <= hold_d;
            win_rstn_q <= win_rstn_d;
            detected_q <= detected_d;
        end
    end

    // Windows are still being cleared in IDLE/FLUSH, so the sample strobe is gated there
    assign sum_in_valid = src_valid && (state_q != IDLE) && (state_q != FLUSH);
    assign win_rstn     = win_rstn_q;
    assign detected     = detected_q;
    assign state        = state_q;

`ifdef PLATEAU_DETECT_CTRL_STATS_EN
    logic [15:0] det_cnt_q, det_cnt_d;

    always_comb begin
        det_cnt_d = det_cnt_q;
        if (restart) begin
            det_cnt_d = '0;
        end else if (detected_q && det_cnt_q != '1) begin
            det_cnt_d = det_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            det_cnt_q <= '0;
        end else begin
            det_cnt_q <= det_cnt_d;
        end
    end

    assign det_count = det_cnt_q;
`endif

endmodule

// File: tb/tb_plateau_detect_ctrl.sv
// Directed bench for plateau_detect_ctrl at default parameters; det_count checks only in the
// PLATEAU_DETECT_CTRL_STATS_EN build.
module tb_plateau_detect_ctrl;

    localparam int W = 22;

    logic         clk;
    logic         rstn;
    logic         enable;
    logic         restart;
    logic         src_valid;
    logic         sum_in_valid;
    logic         win_rstn;
    logic [W-1:0] sum_corr;
    logic [W-1:0] sum_pwr;
    logic         sum_valid;
    logic [2:0]   thresh_num;
    logic         detected;
    logic [2:0]   state;
`ifdef PLATEAU_DETECT_CTRL_STATS_EN
    logic [15:0]  det_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    plateau_detect_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .restart      (restart),
        .src_valid    (src_valid),
        .sum_in_valid (sum_in_valid),
        .win_rstn     (win_rstn),
        .sum_corr     (sum_corr),
        .sum_pwr      (sum_pwr),
        .sum_valid    (sum_valid),
        .thresh_num   (thresh_num),
        .detected     (detected),
        .state        (state)
`ifdef PLATEAU_DETECT_CTRL_STATS_EN
        ,
        .det_count    (det_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n clock edges, each followed by a check that the FSM sits in st with no pulse
    task automatic run_steps(input int n, input logic [2:0] st, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 32'(state), 32'(st));
            chk({tag, "_det"}, 32'(detected), 32'd0);
        end
    endtask

    task automatic set_sums(input logic [2:0] th, input int corr, input int pwr);
        thresh_num = th;
        sum_corr   = W'(corr);
        sum_pwr    = W'(pwr);
    endtask

    initial begin
        rstn      = 1'b0;
        enable    = 1'b0;
        restart   = 1'b0;
        src_valid = 1'b1;
        sum_valid = 1'b0;
        set_sums(3'd4, 51, 100);

        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_win_rstn", 32'(win_rstn), 32'd0);
        chk("rst_sum_in_valid", 32'(sum_in_valid), 32'd0);
        chk("rst_detected", 32'(detected), 32'd0);
        rstn = 1'b1;

        tick();
        chk("idle_hold", 32'(state), 32'd0);

        enable = 1'b1;
        tick();
        chk("flush1_state", 32'(state), 32'd1);
        chk("flush1_win", 32'(win_rstn), 32'd0);
        chk("flush_gate", 32'(sum_in_valid), 32'd0);
        tick();
        chk("flush2_state", 32'(state), 32'd1);
        chk("flush2_win", 32'(win_rstn), 32'd0);
        tick();
        chk("warm_state", 32'(state), 32'd2);
        chk("warm_win", 32'(win_rstn), 32'd1);
        chk("warm_pass_hi", 32'(sum_in_valid), 32'd1);
        src_valid = 1'b0;
        #1;
        chk("warm_pass_lo", 32'(sum_in_valid), 32'd0);
        src_valid = 1'b1;

        // every warm-up sample is a hit; none may count toward detection
        sum_valid = 1'b1;
        run_steps(63, 3'd2, "warmup");
        tick();
        chk("search_entry", 32'(state), 32'd3);

        run_steps(10, 3'd3, "search_a");
        set_sums(3'd4, 51, 0);
        run_steps(1, 3'd3, "pwr_zero");
        set_sums(3'd4, 51, 100);
        run_steps(46, 3'd3, "search_b");
        set_sums(3'd4, 50, 100);
        run_steps(1, 3'd3, "equal_miss");
        set_sums(3'd4, 51, 100);
        run_steps(20, 3'd3, "search_c");
        sum_valid = 1'b0;
        set_sums(3'd4, 0, 100);
        run_steps(5, 3'd3, "no_valid");
        sum_valid = 1'b1;
        set_sums(3'd0, 1, 5);
        run_steps(27, 3'd3, "thresh0");
        tick();
        chk("det1_state", 32'(state), 32'd4);
        chk("det1_pulse", 32'(detected), 32'd1);

        set_sums(3'd4, 51, 100);
        tick();
        chk("hold1_state", 32'(state), 32'd5);
        chk("hold1_pulse_end", 32'(detected), 32'd0);
        run_steps(159, 3'd5, "holdoff");
        tick();
        chk("search2_entry", 32'(state), 32'd3);
        chk("search2_win", 32'(win_rstn), 32'd1);
        run_steps(47, 3'd3, "search2");
        tick();
        chk("det2_state", 32'(state), 32'd4);
        chk("det2_pulse", 32'(detected), 32'd1);
        tick();
        chk("hold2_state", 32'(state), 32'd5);
`ifdef PLATEAU_DETECT_CTRL_STATS_EN
        chk("det_count_2", 32'(det_count), 32'd2);
`endif
        run_steps(3, 3'd5, "hold2");

        restart = 1'b1;
        enable  = 1'b0;
        tick();
        chk("en_over_restart", 32'(state), 32'd0);
        chk("idle_win", 32'(win_rstn), 32'd0);
        chk("idle_gate", 32'(sum_in_valid), 32'd0);
        restart = 1'b0;
        enable  = 1'b1;
        run_steps(2, 3'd1, "reflush");
        tick();
        chk("rewarm_state", 32'(state), 32'd2);
        run_steps(10, 3'd2, "rewarm");

        restart = 1'b1;
        tick();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_win", 32'(win_rstn), 32'd0);
`ifdef PLATEAU_DETECT_CTRL_STATS_EN
        chk("restart_det_count", 32'(det_count), 32'd0);
`endif
        restart = 1'b0;
        tick();
        chk("restart_flush2", 32'(state), 32'd1);
        tick();
        chk("restart_warm", 32'(state), 32'd2);
        // full warm-up length again proves the warm-up counter was cleared
        run_steps(63, 3'd2, "rewarm_full");
        tick();
        chk("research_entry", 32'(state), 32'd3);
        run_steps(5, 3'd3, "research");
        chk("search_pass", 32'(sum_in_valid), 32'd1);

        #1;
        rstn = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_win", 32'(win_rstn), 32'd0);
        chk("arst_gate", 32'(sum_in_valid), 32'd0);
        chk("arst_detected", 32'(detected), 32'd0);
`ifdef PLATEAU_DETECT_CTRL_STATS_EN
        chk("arst_det_count", 32'(det_count), 32'd0);
`endif
        #10;
        rstn = 1'b1;
        tick();
        chk("post_rst_flush", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
